// File: rtl/seq_alu_pkg.sv
// Shared constants for the sequential ALU: op codes, FSM states, default width.
package seq_alu_pkg;

   localparam int WIDTH_DEFAULT = 16;

   localparam logic [4:0] OP_ADD  = 5'd1;
   localparam logic [4:0] OP_SUB  = 5'd2;
   localparam logic [4:0] OP_AND  = 5'd3;
   localparam logic [4:0] OP_NOR  = 5'd4;
   localparam logic [4:0] OP_OR   = 5'd5;
   localparam logic [4:0] OP_LUI  = 5'd7;
   localparam logic [4:0] OP_SLT  = 5'd8;
   localparam logic [4:0] OP_MULT = 5'd9;
   localparam logic [4:0] OP_DIV  = 5'd10;
   localparam logic [4:0] OP_MFHI = 5'd11;
   localparam logic [4:0] OP_MFLO = 5'd12;
   localparam logic [4:0] OP_SLL  = 5'd15;
   localparam logic [4:0] OP_SRL  = 5'd16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle of the sequential ALU, plus the FSM state for observation.
interface seq_alu_if
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
);
   // start is taken only while the ALU is idle; done pulses for one cycle with
   // result and flags valid, and those outputs then hold until the next done.
   logic             start;
   logic [4:0]       op;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             overflow;
   logic             div_by_zero;
   state_t           state;

   modport master (
      output start, op, in1, in2,
      input  busy, done, result, zero, overflow, div_by_zero, state
   );

   modport slave (
      input  start, op, in1, in2,
      output busy, done, result, zero, overflow, div_by_zero, state
   );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative WIDTH-step engine: shift-add unsigned multiply or restoring unsigned divide.
module seq_alu_muldiv #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             finish
);
   localparam int CW = $clog2(WIDTH);

   logic             mode_q;
   logic             busy_q;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] hi_w;
   logic [WIDTH-1:0] lo_w;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   trial;

   // hi/lo present the value after the current step, so on finish they carry the final answer.
   always_comb begin
      add_sum = {1'b0, hi_w} + (lo_w[0] ? {1'b0, b_q} : '0);
      trial   = {hi_w, lo_w[WIDTH-1]} - {1'b0, b_q};
      hi      = hi_w;
      lo      = lo_w;
      if (!mode_q) begin
         hi = add_sum[WIDTH:1];
         lo = {add_sum[0], lo_w[WIDTH-1:1]};
      end else if (trial[WIDTH]) begin
         hi = {hi_w[WIDTH-2:0], lo_w[WIDTH-1]};
         lo = {lo_w[WIDTH-2:0], 1'b0};
      end else begin
         hi = trial[WIDTH-1:0];
         lo = {lo_w[WIDTH-2:0], 1'b1};
      end
   end

   assign finish = busy_q && (count == CW'(WIDTH - 1));
   assign busy   = busy_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         mode_q <= 1'b0;
         count  <= '0;
         b_q    <= '0;
         hi_w   <= '0;
         lo_w   <= '0;
      end else if (start && !busy_q) begin
         busy_q <= 1'b1;
         mode_q <= mode;
         count  <= '0;
         b_q    <= b;
         hi_w   <= '0;
         lo_w   <= a;
      end else if (busy_q) begin
         hi_w  <= hi;
         lo_w  <= lo;
         count <= finish ? '0 : count + CW'(1);
         if (finish) busy_q <= 1'b0;
      end
   end
endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative MULT/DIV into HI/LO.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic     clk,
   input logic     rst_n,
   seq_alu_if.slave bus
);
   state_t           state, state_next;
   logic             md_start, md_mode, md_busy, md_finish, accept_single;
   logic [WIDTH-1:0] md_hi, md_lo, hi_q, lo_q, result_q;
   logic             zero_q, ovf_q, dbz_q, done_q;
   logic [WIDTH-1:0] alu_res, sum, diff;
   logic             alu_ovf, alu_dbz;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      md_start   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start && bus.op == OP_MULT) begin
               md_start   = 1'b1;
               state_next = ST_MUL;
            end else if (bus.start && bus.op == OP_DIV && bus.in2 != '0) begin
               md_start   = 1'b1;
               state_next = ST_DIV;
            end
         end
         ST_MUL, ST_DIV: if (md_finish) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   assign md_mode       = (bus.op == OP_DIV);
   assign accept_single = (state == ST_IDLE) && bus.start && !md_start;
   assign sum           = bus.in1 + bus.in2;
   assign diff          = bus.in1 - bus.in2;

   // DIV only lands here when the divisor is zero; MULT never does.
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_dbz = 1'b0;
      case (bus.op)
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) && (sum[WIDTH-1] != bus.in1[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) && (diff[WIDTH-1] != bus.in1[WIDTH-1]);
         end
         OP_AND:  alu_res = bus.in1 & bus.in2;
         OP_NOR:  alu_res = ~(bus.in1 | bus.in2);
         OP_OR:   alu_res = bus.in1 | bus.in2;
         OP_LUI:  alu_res = bus.in2;
         OP_SLT:  alu_res = ($signed(bus.in1) < $signed(bus.in2)) ? WIDTH'(1) : '0;
         OP_DIV:  alu_dbz = 1'b1;
         OP_MFHI: alu_res = hi_q;
         OP_MFLO: alu_res = lo_q;
         OP_SLL:  alu_res = bus.in1 << bus.in2[SHW-1:0];
         OP_SRL:  alu_res = bus.in1 >> bus.in2[SHW-1:0];
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_q <= '0;
         zero_q   <= 1'b1;
         ovf_q    <= 1'b0;
         dbz_q    <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept_single) begin
            result_q <= alu_res;
            zero_q   <= (alu_res == '0);
            ovf_q    <= alu_ovf;
            dbz_q    <= alu_dbz;
            done_q   <= 1'b1;
         end else if (md_finish) begin
            hi_q     <= md_hi;
            lo_q     <= md_lo;
            result_q <= md_lo;
            zero_q   <= (md_lo == '0);
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b1;
         end
      end
   end

   seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (md_start),
      .mode   (md_mode),
      .a      (bus.in1),
      .b      (bus.in2),
      .busy   (md_busy),
      .hi     (md_hi),
      .lo     (md_lo),
      .finish (md_finish)
   );

   assign bus.busy        = md_busy;
   assign bus.done        = done_q;
   assign bus.result      = result_q;
   assign bus.zero        = zero_q;
   assign bus.overflow    = ovf_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.state       = state;
endmodule

// File: tb/tb_seq_alu.sv
// Directed scoreboard bench for seq_alu at WIDTH=16.
module tb_seq_alu;
   import seq_alu_pkg::*;

   localparam int W  = 16;
   localparam int EW = W + 3;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_e;

   seq_alu_if #(.WIDTH(W)) bus ();

   seq_alu #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // driver: present a request at the falling edge; expected response goes to the scoreboard
   task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.in1   = a;
      bus.in2   = b;
   endtask

   task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] r, input logic z, input logic ov, input logic dz);
      send(op, a, b);
      exp_q.push_back({dz, ov, z, r});
   endtask

   task automatic wait_done(input int lat, input bit inject);
      int  n     = 0;
      int  nbusy = 0;
      bit  seen  = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 1) bus.start = 1'b0;
         if (inject && n == 5) begin
            bus.start = 1'b1;
            bus.op    = OP_ADD;
            bus.in1   = 16'h0001;
            bus.in2   = 16'h0001;
         end
         if (inject && n == 6) bus.start = 1'b0;
         if (bus.busy) nbusy++;
         if (bus.done) seen = 1'b1;
      end
      chk("done_latency", n, lat);
      chk("busy_cycles", nbusy, lat - 1);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 result=%h required no pending request", bus.result);
         end else begin
            mon_e = exp_q.pop_front();
            chk("result", bus.result, mon_e[W-1:0]);
            chk("zero", bus.zero, mon_e[W]);
            chk("overflow", bus.overflow, mon_e[W+1]);
            chk("div_by_zero", bus.div_by_zero, mon_e[W+2]);
         end
      end
   end

   initial begin
      int n;
      int d1;
      int d2;
      int dones;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.in1   = '0;
      bus.in2   = '0;
      repeat (3) @(negedge clk);
      chk("rst_result", bus.result, 0);
      chk("rst_zero", bus.zero, 1);
      chk("rst_overflow", bus.overflow, 0);
      chk("rst_div_by_zero", bus.div_by_zero, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_state", bus.state, ST_IDLE);
      rst_n = 1'b1;

      // single-cycle ops: {op, in1, in2} -> {result, zero, overflow, div_by_zero}
      issue(OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0); wait_done(1, 0);
      issue(OP_SUB,  16'h0005, 16'h0005, 16'h0000, 1, 0, 0); wait_done(1, 0);
      issue(OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 0, 1, 0); wait_done(1, 0);
      issue(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1, 0, 0); wait_done(1, 0);
      issue(OP_SLT,  16'hFFFF, 16'h0001, 16'h0001, 0, 0, 0); wait_done(1, 0);
      issue(OP_SLT,  16'h0001, 16'hFFFF, 16'h0000, 1, 0, 0); wait_done(1, 0);
      issue(OP_AND,  16'hF0F0, 16'hFF00, 16'hF000, 0, 0, 0); wait_done(1, 0);
      issue(OP_OR,   16'h00F0, 16'h0F00, 16'h0FF0, 0, 0, 0); wait_done(1, 0);
      issue(OP_NOR,  16'h0000, 16'h0000, 16'hFFFF, 0, 0, 0); wait_done(1, 0);
      issue(OP_LUI,  16'hAAAA, 16'h1234, 16'h1234, 0, 0, 0); wait_done(1, 0);
      issue(OP_SLL,  16'h0001, 16'h0013, 16'h0008, 0, 0, 0); wait_done(1, 0);
      issue(OP_SRL,  16'h8000, 16'h000F, 16'h0001, 0, 0, 0); wait_done(1, 0);
      issue(5'd6,    16'h1234, 16'h5678, 16'h0000, 1, 0, 0); wait_done(1, 0);
      issue(5'd31,   16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 0); wait_done(1, 0);
      issue(OP_MFHI, 16'h1111, 16'h2222, 16'h0000, 1, 0, 0); wait_done(1, 0);

      // MULT with an ADD pulsed mid-operation that must be ignored
      issue(OP_MULT, 16'd300, 16'd500, 16'h49F0, 0, 0, 0); wait_done(17, 1);
      issue(OP_MFHI, 16'h0000, 16'h0000, 16'h0002, 0, 0, 0); wait_done(1, 0);
      issue(OP_MFLO, 16'h0000, 16'h0000, 16'h49F0, 0, 0, 0); wait_done(1, 0);

      // DIV, divide-by-zero, and a zero quotient
      issue(OP_DIV,  16'd1000, 16'd7, 16'd142, 0, 0, 0); wait_done(17, 0);
      issue(OP_MFHI, 16'h0000, 16'h0000, 16'd6, 0, 0, 0); wait_done(1, 0);
      issue(OP_DIV,  16'd5, 16'd0, 16'h0000, 1, 0, 1); wait_done(1, 0);
      issue(OP_MFLO, 16'h0000, 16'h0000, 16'd142, 0, 0, 0); wait_done(1, 0);
      issue(OP_MFHI, 16'h0000, 16'h0000, 16'd6, 0, 0, 0); wait_done(1, 0);
      issue(OP_DIV,  16'd3, 16'd7, 16'h0000, 1, 0, 0); wait_done(17, 0);
      issue(OP_MFHI, 16'h0000, 16'h0000, 16'd3, 0, 0, 0); wait_done(1, 0);

      // start held across MULT completion: the ADD is taken one cycle after done
      issue(OP_MULT, 16'hFFFF, 16'hFFFF, 16'h0001, 0, 0, 0);
      n = 0; d1 = 0; d2 = 0;
      while (d2 == 0 && n < 45) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            bus.op  = OP_ADD;
            bus.in1 = 16'h0002;
            bus.in2 = 16'h0003;
            exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h0005});
         end
         if (bus.done) begin
            if (d1 == 0) d1 = n;
            else         d2 = n;
         end
      end
      bus.start = 1'b0;
      chk("held_mult_done", d1, 17);
      chk("held_add_done", d2, 18);
      issue(OP_MFHI, 16'h0000, 16'h0000, 16'hFFFE, 0, 0, 0); wait_done(1, 0);

      // reset in the middle of a DIV aborts it
      send(OP_DIV, 16'd1000, 16'd3);
      repeat (8) @(negedge clk) bus.start = 1'b0;
      chk("abort_busy_before", bus.busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy_after", bus.busy, 0);
      chk("abort_state_after", bus.state, ST_IDLE);
      chk("abort_done_after", bus.done, 0);
      rst_n = 1'b1;
      dones = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      chk("abort_no_done", dones, 0);
      issue(OP_MFLO, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0); wait_done(1, 0);
      issue(OP_MFHI, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0); wait_done(1, 0);

      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
